// File: rtl/proc_pkg.sv
// Shared definitions for the multicycle MIPS-subset processor_core.
// Optional bne support is enabled by defining PROC_BNE_EN.
package proc_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTE, ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP
  } stateT;

  typedef enum logic [2:0] {ADD, SUB, AND, OR, SLT} aluCtrlT;

  function automatic logic validFunct(input logic [5:0] funct);
    return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
           (funct == FN_OR)  || (funct == FN_SLT);
  endfunction

  function automatic aluCtrlT functToAlu(input logic [5:0] funct);
    case (funct)
      FN_SUB:  return SUB;
      FN_AND:  return AND;
      FN_OR:   return OR;
      FN_SLT:  return SLT;
      default: return ADD;
    endcase
  endfunction

endpackage

// File: rtl/proc_alu.sv
// 32-bit ALU for processor_core: add, sub, and, or, signed set-less-than.
module proc_alu
  import proc_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  aluCtrlT     ctrl,
  output logic [31:0] result,
  output logic        zero
);

  always_comb begin
    result = '0;
    case (ctrl)
      ADD:     result = a + b;
      SUB:     result = a - b;
      AND:     result = a & b;
      OR:      result = a | b;
      SLT:     result = {31'b0, $signed(a) < $signed(b)};
      default: result = a + b;
    endcase
  end

  assign zero = (result == 32'd0);

endmodule

// File: rtl/processor_core.sv
// Multicycle MIPS-subset CPU sharing one memory port for fetch and data.
// Define PROC_BNE_EN to add bne (opcode 0x05); otherwise it decodes as a NOP.
module processor_core
  import proc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] Mem_DataIn,
  output logic [31:0] Mem_Address,
  output logic        Mem_WriteEnable,
  output logic [31:0] Mem_DataOut
);

  stateT       state;
  stateT       decodeNext;
  logic [31:0] pc, ir, mdr, regA, regB, aluOut;
  logic [31:0] regFile [32];

  logic [31:0] aluA, aluB, aluResult;
  aluCtrlT     aluCtrl;
  logic        aluZero, branchTaken;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] signExt;

  assign opcode  = ir[31:26];
  assign rs      = ir[25:21];
  assign rt      = ir[20:16];
  assign rd      = ir[15:11];
  assign funct   = ir[5:0];
  assign signExt = {{16{ir[15]}}, ir[15:0]};

  // One ALU serves PC increment, branch target, address and arithmetic steps.
  always_comb begin
    aluA    = pc;
    aluB    = 32'd4;
    aluCtrl = ADD;
    case (state)
      DECODE: aluB = signExt << 2;
      MEMADR, ADDIEX: begin
        aluA = regA;
        aluB = signExt;
      end
      EXECUTE: begin
        aluA    = regA;
        aluB    = regB;
        aluCtrl = functToAlu(funct);
      end
      BRANCH: begin
        aluA    = regA;
        aluB    = regB;
        aluCtrl = SUB;
      end
      default: ;
    endcase
  end

  proc_alu alu (
    .a      (aluA),
    .b      (aluB),
    .ctrl   (aluCtrl),
    .result (aluResult),
    .zero   (aluZero)
  );

`ifdef PROC_BNE_EN
  assign branchTaken = (opcode == OP_BNE) ? !aluZero : aluZero;
`else
  assign branchTaken = aluZero;
`endif

  // Unrecognised opcodes and functs fall back to FETCH, acting as a NOP.
  always_comb begin
    decodeNext = FETCH;
    case (opcode)
      OP_LW, OP_SW: decodeNext = MEMADR;
      OP_RTYPE:     decodeNext = validFunct(funct) ? EXECUTE : FETCH;
      OP_ADDI:      decodeNext = ADDIEX;
      OP_BEQ:       decodeNext = BRANCH;
`ifdef PROC_BNE_EN
      OP_BNE:       decodeNext = BRANCH;
`endif
      OP_J:         decodeNext = JUMP;
      default:      decodeNext = FETCH;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state  <= FETCH;
      pc     <= RESET_PC;
      ir     <= '0;
      mdr    <= '0;
      regA   <= '0;
      regB   <= '0;
      aluOut <= '0;
      for (int i = 0; i < 32; i++) regFile[i] <= '0;
    end else begin
      case (state)
        FETCH: begin
          ir    <= Mem_DataIn;
          pc    <= aluResult;
          state <= DECODE;
        end
        DECODE: begin
          regA   <= regFile[rs];
          regB   <= regFile[rt];
          aluOut <= aluResult;
          state  <= decodeNext;
        end
        MEMADR: begin
          aluOut <= aluResult;
          state  <= (opcode == OP_LW) ? MEMREAD : MEMWRITE;
        end
        MEMREAD: begin
          mdr   <= Mem_DataIn;
          state <= MEMWB;
        end
        MEMWB: begin
          if (rt != 5'd0) regFile[rt] <= mdr;
          state <= FETCH;
        end
        MEMWRITE: state <= FETCH;
        EXECUTE: begin
          aluOut <= aluResult;
          state  <= ALUWB;
        end
        ALUWB: begin
          if (rd != 5'd0) regFile[rd] <= aluOut;
          state <= FETCH;
        end
        ADDIEX: begin
          aluOut <= aluResult;
          state  <= ADDIWB;
        end
        ADDIWB: begin
          if (rt != 5'd0) regFile[rt] <= aluOut;
          state <= FETCH;
        end
        BRANCH: begin
          if (branchTaken) pc <= aluOut;
          state <= FETCH;
        end
        JUMP: begin
          pc    <= {pc[31:28], ir[25:0], 2'b00};
          state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

  // The store strobe is gated by Reset so an aborted sw never reaches RAM.
  assign Mem_Address     = (state == MEMREAD || state == MEMWRITE) ? aluOut : pc;
  assign Mem_DataOut     = regB;
  assign Mem_WriteEnable = (state == MEMWRITE) && Reset;

endmodule

// File: tb/tb_processor_core.sv
// Directed self-checking bench for processor_core with a 16K x 32 RAM model.
module tb_processor_core;
  import proc_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] memDataIn, memAddress, memDataOut;
  logic        memWriteEnable;
  logic [31:0] ram [16384];

  int checks   = 0;
  int failures = 0;

  processor_core dut (
    .Clock           (clock),
    .Reset           (reset),
    .Mem_DataIn      (memDataIn),
    .Mem_Address     (memAddress),
    .Mem_WriteEnable (memWriteEnable),
    .Mem_DataOut     (memDataOut)
  );

  always #5 clock = ~clock;

  assign memDataIn = ram[memAddress[15:2]];

  always @(posedge clock)
    if (memWriteEnable) ram[memAddress[15:2]] <= memDataOut;

  function automatic logic [31:0] rType(input int rs, input int rt, input int rd,
                                        input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
  endfunction

  function automatic logic [31:0] iType(input logic [5:0] op, input int rs, input int rt,
                                        input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Holds Reset at the given level for a number of rising edges, then samples 1ns later.
  task automatic applyStimulus(input logic rst, input int cycles);
    reset = rst;
    repeat (cycles) @(posedge clock);
    #1;
  endtask

  task automatic resetCpu();
    applyStimulus(1'b0, 1);
    reset = 1'b1;
  endtask

  task automatic clearRam();
    for (int i = 0; i < 16384; i++) ram[i] = 32'd0;
  endtask

  initial begin
    int weCount;
    logic [31:0] weAddr, weData;

    // Reset then addi $1,$0,5
    clearRam();
    ram[0] = iType(OP_ADDI, 0, 1, 16'd5);
    resetCpu();
    checkOutput("resetAddr", memAddress, 32'h0);
    checkOutput("resetState", 32'(dut.state), 32'(FETCH));
    checkOutput("resetWe", 32'(memWriteEnable), 32'd0);
    checkOutput("resetIr", dut.ir, 32'd0);
    applyStimulus(1'b1, 4);
    checkOutput("addiR1", dut.regFile[1], 32'd5);
    checkOutput("addiPc", dut.pc, 32'd4);
    checkOutput("addiState", 32'(dut.state), 32'(FETCH));

    // R-type sequence including a write to $zero
    clearRam();
    ram[0] = iType(OP_ADDI, 0, 1, 16'd5);
    ram[1] = iType(OP_ADDI, 0, 2, 16'hFFFD);
    ram[2] = rType(1, 2, 3, FN_ADD);
    ram[3] = rType(2, 1, 4, FN_SLT);
    ram[4] = rType(1, 2, 0, FN_SUB);
    resetCpu();
    applyStimulus(1'b1, 20);
    checkOutput("rtypeR2", dut.regFile[2], 32'hFFFF_FFFD);
    checkOutput("rtypeR3", dut.regFile[3], 32'd2);
    checkOutput("rtypeR4", dut.regFile[4], 32'd1);
    checkOutput("rtypeR0", dut.regFile[0], 32'd0);
    checkOutput("rtypePc", dut.pc, 32'd20);

    // Store then load through the shared port
    clearRam();
    ram[0] = iType(OP_ADDI, 0, 1, 16'd5);
    ram[1] = iType(OP_SW, 0, 1, 16'h0100);
    ram[2] = iType(OP_LW, 0, 5, 16'h0100);
    resetCpu();
    applyStimulus(1'b1, 4);
    weCount = 0;
    weAddr  = '0;
    weData  = '0;
    for (int i = 0; i < 4; i++) begin
      if (memWriteEnable) begin
        weCount++;
        weAddr = memAddress;
        weData = memDataOut;
      end
      applyStimulus(1'b1, 1);
    end
    checkOutput("swWeCount", 32'(weCount), 32'd1);
    checkOutput("swAddr", weAddr, 32'h100);
    checkOutput("swData", weData, 32'd5);
    checkOutput("swRam", ram[64], 32'd5);
    checkOutput("swPc", dut.pc, 32'd8);
    applyStimulus(1'b1, 4);
    checkOutput("lwState4", 32'(dut.state), 32'(MEMWB));
    checkOutput("lwR5Early", dut.regFile[5], 32'd0);
    applyStimulus(1'b1, 1);
    checkOutput("lwR5", dut.regFile[5], 32'd5);
    checkOutput("lwPc", dut.pc, 32'd12);

    // beq $1,$1,-1 at 0x20 loops forever
    clearRam();
    ram[0] = iType(OP_ADDI, 0, 1, 16'd5);
    ram[8] = iType(OP_BEQ, 1, 1, 16'hFFFF);
    resetCpu();
    applyStimulus(1'b1, 18);
    checkOutput("beqStartPc", dut.pc, 32'h20);
    applyStimulus(1'b1, 2);
    checkOutput("beqMidPc", dut.pc, 32'h24);
    applyStimulus(1'b1, 1);
    checkOutput("beqLoop1", dut.pc, 32'h20);
    checkOutput("beqLoopState", 32'(dut.state), 32'(FETCH));
    applyStimulus(1'b1, 3);
    checkOutput("beqLoop2", dut.pc, 32'h20);

    // beq with unequal operands falls through
    ram[8] = iType(OP_BEQ, 1, 2, 16'hFFFF);
    resetCpu();
    applyStimulus(1'b1, 21);
    checkOutput("beqFallPc", dut.pc, 32'h24);

    // j 0x40 at 0x10
    clearRam();
    ram[4] = {OP_J, 26'h10};
    resetCpu();
    applyStimulus(1'b1, 8);
    checkOutput("jStartPc", dut.pc, 32'h10);
    applyStimulus(1'b1, 2);
    checkOutput("jMidPc", dut.pc, 32'h14);
    applyStimulus(1'b1, 1);
    checkOutput("jPc", dut.pc, 32'h40);

    // Reset asserted during MEMWRITE aborts the store
    clearRam();
    ram[0] = iType(OP_ADDI, 0, 1, 16'd5);
    ram[1] = iType(OP_SW, 0, 1, 16'h0200);
    resetCpu();
    applyStimulus(1'b1, 7);
    checkOutput("abortWeBefore", 32'(memWriteEnable), 32'd1);
    checkOutput("abortAddr", memAddress, 32'h200);
    reset = 1'b0;
    #1;
    checkOutput("abortWeGated", 32'(memWriteEnable), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    checkOutput("abortRam", ram[128], 32'd0);
    checkOutput("abortPc", dut.pc, 32'd0);
    checkOutput("abortState", 32'(dut.state), 32'(FETCH));
    checkOutput("abortR1", dut.regFile[1], 32'd0);

    // Unknown opcode 0x3F is a 2-cycle NOP
    clearRam();
    ram[0] = iType(OP_ADDI, 0, 1, 16'd5);
    ram[1] = iType(6'h3F, 1, 2, 16'hFFFF);
    resetCpu();
    applyStimulus(1'b1, 6);
    checkOutput("nopPc", dut.pc, 32'd8);
    checkOutput("nopState", 32'(dut.state), 32'(FETCH));
    checkOutput("nopR1", dut.regFile[1], 32'd5);
    checkOutput("nopR2", dut.regFile[2], 32'd0);

    // bne $1,$0,-1 at 0x4: branch loop when enabled, NOP otherwise
    clearRam();
    ram[0] = iType(OP_ADDI, 0, 1, 16'd5);
    ram[1] = iType(OP_BNE, 1, 0, 16'hFFFF);
    resetCpu();
    applyStimulus(1'b1, 4);
`ifdef PROC_BNE_EN
    applyStimulus(1'b1, 3);
    checkOutput("bneTakenPc", dut.pc, 32'd4);
`else
    applyStimulus(1'b1, 2);
    checkOutput("bneNopPc", dut.pc, 32'd8);
`endif
    checkOutput("bneState", 32'(dut.state), 32'(FETCH));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
